uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Next-generation single-clock UART core: TX and RX share one clock and a runtime baud divisor, replacing separate TX/RX clocks.
- Adds a parametrised TX FIFO with ready/valid backpressure, 1/2 stop bits, and RX parity/framing error reporting.
- Sits between a parallel system bus and the serial pins; serial framing is LSB-first.

Parameters:
- WIDTH, 8, data bits per frame (5..9).
- DEPTH, 4, TX FIFO entries; power of 2, >=2.
- DIV_WIDTH, 16, width of baud_div.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- baud_div  in  DIV_WIDTH  CLK cycles per bit; values <2 are treated as 2.
- parity_enable  in  1  1 = parity bit present.
- parity_type  in  1  0 = even, 1 = odd.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits (TX); RX checks only the first.
- TX_IN_P  in  WIDTH  transmit data.
- TX_IN_V  in  1  transmit data valid.
- TX_IN_R  out  1  FIFO can accept (= not full).
- TX_OUT_S  out  1  serial out, idle high.
- TX_Busy  out  1  FSM not IDLE or FIFO non-empty.
- RX_IN_S  in  1  serial in, asynchronous.
- RX_OUT_P  out  WIDTH  received data.
- RX_OUT_V  out  1  one-cycle valid pulse.
- parity_error  out  1  qualified by RX_OUT_V.
- framing_error  out  1  qualified by RX_OUT_V.

Behaviour:
- Reset values: TX_OUT_S=1, TX_IN_R=1, TX_Busy=0, RX_OUT_P=0, RX_OUT_V=0, parity_error=0, framing_error=0. FIFO emptied, both FSMs to IDLE, counters cleared.
- Reset mid-frame aborts the frame; TX_OUT_S is high the cycle after reset.
- FIFO write:
  - A write occurs on an edge where TX_IN_V & TX_IN_R.
  - When full, TX_IN_R=0 and writes are refused even if a pop occurs on the same edge.
  - Push and pop on the same edge when non-empty leaves the count unchanged.
  - Pointers wrap modulo DEPTH; the count is log2(DEPTH)+1 bits.
- TX FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: if FIFO is non-empty, pop, latch data, parity_enable, parity_type and stop_bits, and drive TX_OUT_S=0.
  - Timing: a byte accepted at edge E0 into an empty FIFO with an IDLE FSM is popped at E1; TX_OUT_S is low from E1.
  - Each bit lasts exactly max(baud_div,2) cycles. baud_div is sampled at each bit start.
  - DATA sends WIDTH bits, LSB first.
  - PARITY bit = XOR of the data bits, inverted when odd.
  - STOP lasts 1 or 2 bit periods high.
  - Back-to-back: if the FIFO is non-empty at the end of STOP, the next START begins on the following cycle with no extra idle.
  - TX_OUT_S is registered.
- RX FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - RX_IN_S passes through a 2-flop synchroniser.
  - IDLE: the synchronised line falling 1->0 enters START; counter loads half-period = max(baud_div,2)>>1.
  - START: at half-period, if the line is low go to DATA; else return to IDLE (glitch rejected).
  - DATA/PARITY/STOP: sample once every full period thereafter (mid-bit). DATA shifts LSB first.
  - PARITY: parity_error = sampled bit differs from the computed parity.
  - STOP: framing_error = sampled bit is 0.
  - Cycle after the stop sample: RX_OUT_V=1 for exactly one cycle with RX_OUT_P and both flags, then IDLE. Flags are updated every frame.
  - RX_OUT_V has no backpressure; the consumer must take the data on the pulse.
- Runtime config changes mid-frame: TX uses the latched config; RX samples parity_enable and parity_type at the START->DATA transition.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- When defined:
  - Adds input port loopback (1 bit).
  - loopback=1 feeds the RX synchroniser from the internal TX serial line and holds the TX_OUT_S pin at 1.
  - RX_IN_S is ignored while loopback=1.
  - loopback=0 gives normal operation.
- When undefined: the port is absent and the RX path is always RX_IN_S.

Decomposition:
- Package uart_pkg:
  - TX/RX state encodings.
  - Parity constants: PAR_EVEN=0, PAR_ODD=1.
  - Stop-bit constants.
  - MIN_DIV=2.
- Sub-module uart_sync_fifo (WIDTH, DEPTH): synchronous FIFO with full/empty flags, same CLK/RST.
- TX FSM, RX FSM and the synchroniser live in uart_core.

Test Plan:
- Reset, baud_div=16, no parity, 1 stop; write 0xA5 -> TX_OUT_S low for 16 cycles from E1, then 1,0,1,0,0,1,0,1 each 16 cycles, then high 16 cycles; TX_Busy drops after 160 cycles.
- parity_enable=1, write 0x03 with even then odd parity; stop_bits=1 -> parity bit 0 then 1; stop high for 32 cycles; frames are 192 cycles.
- DEPTH=4, TX_IN_V held high from idle -> exactly 5 bytes accepted, TX_IN_R=0 until the first frame's STOP ends; all 5 bytes are sent back-to-back in order.
- TX_OUT_S wired to RX_IN_S, odd parity, send 0x5A -> one RX_OUT_V pulse with RX_OUT_P=0x5A, parity_error=0, framing_error=0.
- Drive an RX frame of 0x3C with stop=0 -> RX_OUT_V with framing_error=1. Then a frame with an inverted parity bit -> parity_error=1.
- 3-cycle low glitch on RX_IN_S (baud_div=16) -> no RX_OUT_V. Assert RST mid-TX-frame -> TX_OUT_S=1, FIFO empty, TX_Busy=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and framing constants for uart_core.
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  typedef enum logic {PAR_EVEN = 1'b0, PAR_ODD = 1'b1} parity_t;
  typedef enum logic {STOP_ONE = 1'b0, STOP_TWO = 1'b1} stop_t;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/uart_if.sv
// uart_if: parallel-side TX write handshake and RX result bus of uart_core.
interface uart_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] TX_IN_P;
  logic             TX_IN_V;
  logic             TX_IN_R;
  logic [WIDTH-1:0] RX_OUT_P;
  logic             RX_OUT_V;
  logic             parity_error;
  logic             framing_error;
  modport master (output TX_IN_P, TX_IN_V, input TX_IN_R, RX_OUT_P, RX_OUT_V, parity_error, framing_error);
  modport slave (input TX_IN_P, TX_IN_V, output TX_IN_R, RX_OUT_P, RX_OUT_V, parity_error, framing_error);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO; writes refused when full, reads ignored when empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign dout  = mem[rptr];
  always_ff @(posedge CLK)
    if (wr) mem[wptr] <= din;
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(wr);
      rptr  <= rptr + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/uart_core.sv
// uart_core: single-clock UART, FIFO-buffered TX and error-flagging RX on a shared baud divisor.
// Defining UART_LOOPBACK_EN adds a loopback input routing TX back into RX internally.
module uart_core import uart_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_enable,
  input  logic                 parity_type,
  input  logic                 stop_bits,
  output logic                 TX_OUT_S,
  output logic                 TX_Busy,
  input  logic                 RX_IN_S,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  uart_if.slave                bus
);
  logic [DIV_WIDTH-1:0] div, half, tx_cnt, rx_cnt;
  logic [WIDTH-1:0] fifo_dout, tx_sh, rx_sh;
  logic [3:0] tx_bit, rx_bit;
  logic fifo_full, fifo_empty, pop, tx_tick, tx_d, tx_s, tx_par_en, tx_par, tx_stop;
  logic rx_src, s1, s2, s3, rx_tick, rx_done, rx_pen, rx_ptype, rx_perr;
  state_t tx_state, tx_nxt, rx_state, rx_nxt;
  assign div  = baud_div < DIV_WIDTH'(MIN_DIV) ? DIV_WIDTH'(MIN_DIV) : baud_div;
  assign half = div >> 1;
`ifdef UART_LOOPBACK_EN
  assign rx_src   = loopback ? tx_s : RX_IN_S;
  assign TX_OUT_S = loopback | tx_s;
`else
  assign rx_src   = RX_IN_S;
  assign TX_OUT_S = tx_s;
`endif
  uart_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo (
    .CLK(CLK), .RST(RST), .push(bus.TX_IN_V), .pop(pop), .din(bus.TX_IN_P),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );
  assign bus.TX_IN_R = ~fifo_full;
  assign TX_Busy     = tx_state != ST_IDLE || !fifo_empty;
  assign tx_tick     = tx_cnt == '0;
  // tx_d is the line level for the next cycle, so TX_OUT_S stays registered
  always_comb begin
    tx_nxt = tx_state;
    pop = 1'b0;
    tx_d = 1'b1;
    case (tx_state)
      ST_IDLE: if (!fifo_empty) begin
        pop = 1'b1;
        tx_nxt = ST_START;
        tx_d = 1'b0;
      end
      ST_START: begin
        tx_nxt = tx_tick ? ST_DATA : ST_START;
        tx_d = tx_tick & tx_sh[0];
      end
      ST_DATA: if (!tx_tick) tx_d = tx_sh[0];
        else if (tx_bit != 4'(WIDTH-1)) tx_d = tx_sh[1];
        else begin
          tx_nxt = tx_par_en ? ST_PARITY : ST_STOP;
          tx_d = tx_par_en ? tx_par : 1'b1;
        end
      ST_PARITY: begin
        tx_nxt = tx_tick ? ST_STOP : ST_PARITY;
        tx_d = tx_tick | tx_par;
      end
      ST_STOP: if (tx_tick && tx_bit == 4'(tx_stop == STOP_TWO)) begin
        pop = !fifo_empty;
        tx_nxt = fifo_empty ? ST_IDLE : ST_START;
        tx_d = fifo_empty;
      end
      default: tx_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state  <= ST_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      tx_par_en <= 1'b0;
      tx_par    <= 1'b0;
      tx_stop   <= 1'b0;
      tx_s      <= 1'b1;
    end else begin
      tx_state <= tx_nxt;
      tx_s     <= tx_d;
      tx_cnt   <= (pop || (tx_state != ST_IDLE && tx_tick)) ? div - DIV_WIDTH'(1) : tx_cnt - DIV_WIDTH'(!tx_tick);
      tx_bit   <= tx_nxt != tx_state ? '0 : tx_bit + 4'(tx_tick);
      if (pop) begin
        tx_sh     <= fifo_dout;
        tx_par_en <= parity_enable;
        tx_par    <= ^fifo_dout ^ (parity_type == PAR_ODD);
        tx_stop   <= stop_bits;
      end else if (tx_state == ST_DATA && tx_tick) tx_sh <= tx_sh >> 1;
    end
  end
  assign rx_tick = rx_cnt == '0;
  assign rx_done = rx_state == ST_STOP && rx_tick;
  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      ST_IDLE:   if (s3 && !s2) rx_nxt = ST_START;
      ST_START:  if (rx_tick) rx_nxt = s2 ? ST_IDLE : ST_DATA;
      ST_DATA:   if (rx_tick && rx_bit == 4'(WIDTH-1)) rx_nxt = rx_pen ? ST_PARITY : ST_STOP;
      ST_PARITY: if (rx_tick) rx_nxt = ST_STOP;
      ST_STOP:   if (rx_tick) rx_nxt = ST_IDLE;
      default:   rx_nxt = ST_IDLE;
    endcase
  end
  // IDLE keeps reloading the half period so START samples mid start-bit
  always_ff @(posedge CLK) begin
    if (RST) begin
      {s3, s2, s1}      <= 3'b111;
      rx_state          <= ST_IDLE;
      rx_cnt            <= '0;
      rx_bit            <= '0;
      rx_sh             <= '0;
      rx_pen            <= 1'b0;
      rx_ptype          <= 1'b0;
      rx_perr           <= 1'b0;
      bus.RX_OUT_P      <= '0;
      bus.RX_OUT_V      <= 1'b0;
      bus.parity_error  <= 1'b0;
      bus.framing_error <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, rx_src};
      rx_state     <= rx_nxt;
      rx_cnt       <= rx_state == ST_IDLE ? half - DIV_WIDTH'(1) : rx_tick ? div - DIV_WIDTH'(1) : rx_cnt - DIV_WIDTH'(1);
      rx_bit       <= rx_nxt != rx_state ? '0 : rx_bit + 4'(rx_tick);
      bus.RX_OUT_V <= rx_done;
      if (rx_state == ST_START && rx_nxt == ST_DATA) begin
        rx_pen   <= parity_enable;
        rx_ptype <= parity_type;
        rx_perr  <= 1'b0;
      end
      if (rx_state == ST_DATA && rx_tick) rx_sh <= {s2, rx_sh[WIDTH-1:1]};
      if (rx_state == ST_PARITY && rx_tick) rx_perr <= s2 != (^rx_sh ^ (rx_ptype == PAR_ODD));
      if (rx_done) begin
        bus.RX_OUT_P      <= rx_sh;
        bus.parity_error  <= rx_perr;
        bus.framing_error <= !s2;
      end
    end
  end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: table-driven TX/RX frame vectors plus FIFO, error, glitch and reset sequences.
module tb_uart_core;
  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        pe;
    logic        pt;
    logic        sb;
    logic [11:0] frame;
    int          len;
  } vec_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [15:0] baud_div = 16'd16;
  logic parity_enable = 1'b0, parity_type = 1'b0, stop_bits = 1'b0;
  logic TX_OUT_S, TX_Busy, RX_IN_S;
  logic rx_drv = 1'b1, loop_mode = 1'b0;
  logic [7:0] tx_p = 8'h00;
  logic tx_v = 1'b0;
  int n_chk = 0, n_fail = 0, cyc = 0, acc_n = 0, rx_n = 0;
  logic [7:0] rxq[$];
  logic last_pe = 1'b0, last_fe = 1'b0;
  vec_t vt[6];
  uart_if #(.WIDTH(8)) bus();
  assign bus.TX_IN_P = tx_p;
  assign bus.TX_IN_V = tx_v;
  assign RX_IN_S = loop_mode ? TX_OUT_S : rx_drv;
  uart_core #(.WIDTH(8), .DEPTH(4), .DIV_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .baud_div(baud_div), .parity_enable(parity_enable),
    .parity_type(parity_type), .stop_bits(stop_bits), .TX_OUT_S(TX_OUT_S),
    .TX_Busy(TX_Busy), .RX_IN_S(RX_IN_S), .bus(bus)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (tx_v && bus.TX_IN_R) acc_n <= acc_n + 1;
  end
  always @(negedge CLK)
    if (bus.RX_OUT_V) begin
      rx_n <= rx_n + 1;
      rxq.push_back(bus.RX_OUT_P);
      last_pe <= bus.parity_error;
      last_fe <= bus.framing_error;
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask
  task automatic drive_rx(input logic [11:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      rx_drv = bits[i];
      repeat (16) step();
    end
    rx_drv = 1'b1;
    repeat (40) step();
  endtask
  task automatic chk_rx(input string nm, input int n0, input int q0, input logic [7:0] d, input logic pe, input logic fe);
    logic [7:0] got;
    got = rxq.size() > q0 ? rxq[q0] : 8'hxx;
    chk({nm, "_pulses"}, rx_n - n0, 1);
    chk({nm, "_data"}, got, d);
    chk({nm, "_perr"}, last_pe, pe);
    chk({nm, "_ferr"}, last_fe, fe);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int d, n0, q0, a0, e0;
    vt[0] = '{8'hA5, 16'd16, 1'b0, 1'b0, 1'b0, 12'h34A, 10};
    vt[1] = '{8'h03, 16'd16, 1'b1, 1'b0, 1'b1, 12'hC06, 12};
    vt[2] = '{8'h03, 16'd16, 1'b1, 1'b1, 1'b1, 12'hE06, 12};
    vt[3] = '{8'h5A, 16'd16, 1'b1, 1'b1, 1'b0, 12'h6B4, 11};
    vt[4] = '{8'h80, 16'd4,  1'b1, 1'b0, 1'b0, 12'h700, 11};
    vt[5] = '{8'hFF, 16'd1,  1'b0, 1'b0, 1'b1, 12'h7FE, 11};
    repeat (3) step();
    RST = 1'b0;
    chk("rst_tx_s", TX_OUT_S, 1);
    chk("rst_tx_r", bus.TX_IN_R, 1);
    chk("rst_busy", TX_Busy, 0);
    chk("rst_rx_p", bus.RX_OUT_P, 0);
    chk("rst_rx_v", bus.RX_OUT_V, 0);
    chk("rst_perr", bus.parity_error, 0);
    chk("rst_ferr", bus.framing_error, 0);
    repeat (4) step();
    loop_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = vt[i].div < 16'd2 ? 2 : int'(vt[i].div);
      baud_div = vt[i].div;
      parity_enable = vt[i].pe;
      parity_type = vt[i].pt;
      stop_bits = vt[i].sb;
      n0 = rx_n;
      q0 = rxq.size();
      tx_p = vt[i].data;
      tx_v = 1'b1;
      step();
      tx_v = 1'b0;
      step();
      for (int c = 0; c < vt[i].len * d; c++) begin
        if (c % d == 0 || c % d == d - 1)
          chk($sformatf("v%0d_bit%0d_c%0d", i, c / d, c), TX_OUT_S, vt[i].frame[c / d]);
        if (c == vt[i].len * d - 1) chk($sformatf("v%0d_busy_last", i), TX_Busy, 1);
        step();
      end
      chk($sformatf("v%0d_busy_done", i), TX_Busy, 0);
      chk($sformatf("v%0d_line_idle", i), TX_OUT_S, 1);
      repeat (3 * d + 8) step();
      chk_rx($sformatf("v%0d_rx", i), n0, q0, vt[i].data, 1'b0, 1'b0);
    end
    baud_div = 16'd16;
    parity_enable = 1'b0;
    stop_bits = 1'b0;
    q0 = rxq.size();
    n0 = rx_n;
    a0 = acc_n;
    tx_p = 8'h10;
    tx_v = 1'b1;
    step();
    e0 = cyc;
    while (cyc < e0 + 160) begin
      tx_p = 8'h10 + 8'(acc_n - a0);
      step();
    end
    chk("fill_accepted", acc_n - a0, 5);
    chk("fill_full_r", bus.TX_IN_R, 0);
    step();
    tx_v = 1'b0;
    chk("fill_pop_r", bus.TX_IN_R, 1);
    chk("fill_refused", acc_n - a0, 5);
    wait_cyc(e0 + 800);
    chk("fill_busy_last", TX_Busy, 1);
    step();
    chk("fill_busy_done", TX_Busy, 0);
    repeat (40) step();
    chk("fill_rx_count", rx_n - n0, 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("fill_rx%0d", k), rxq.size() > q0 + k ? rxq[q0 + k] : 8'hxx, 8'h10 + 8'(k));
    loop_mode = 1'b0;
    rx_drv = 1'b1;
    repeat (20) step();
    n0 = rx_n;
    q0 = rxq.size();
    drive_rx(12'h078, 10);
    chk_rx("rx_badstop", n0, q0, 8'h3C, 1'b0, 1'b1);
    parity_enable = 1'b1;
    parity_type = 1'b0;
    n0 = rx_n;
    q0 = rxq.size();
    drive_rx(12'h678, 11);
    chk_rx("rx_badpar", n0, q0, 8'h3C, 1'b1, 1'b0);
    parity_type = 1'b1;
    n0 = rx_n;
    q0 = rxq.size();
    drive_rx(12'h678, 11);
    chk_rx("rx_oddpar", n0, q0, 8'h3C, 1'b0, 1'b0);
    parity_enable = 1'b0;
    n0 = rx_n;
    rx_drv = 1'b0;
    repeat (3) step();
    rx_drv = 1'b1;
    repeat (60) step();
    chk("rx_glitch", rx_n - n0, 0);
    q0 = rxq.size();
    drive_rx(12'h278, 10);
    chk_rx("rx_after_glitch", n0, q0, 8'h3C, 1'b0, 1'b0);
    tx_p = 8'hC3;
    tx_v = 1'b1;
    step();
    tx_p = 8'h3C;
    step();
    tx_v = 1'b0;
    repeat (50) step();
    chk("mid_busy", TX_Busy, 1);
    chk("mid_line_low", TX_OUT_S, 0);
    RST = 1'b1;
    step();
    chk("abort_line", TX_OUT_S, 1);
    chk("abort_busy", TX_Busy, 0);
    chk("abort_ready", bus.TX_IN_R, 1);
    RST = 1'b0;
    repeat (20) step();
    chk("abort_stays_idle", TX_Busy, 0);
    chk("abort_line_idle", TX_OUT_S, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
